// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control unit: states, instruction
// types, per-type function codes, ALU operations, PC sources and decode classes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_TRAP = 3'd6
  } state_t;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;
  localparam logic [1:0] TYPE_S = 2'b11;

  localparam int F_AND  = 0;
  localparam int F_ADD  = 1;
  localparam int F_SUB  = 2;
  localparam int F_CMP  = 3;
  localparam int F_ANDI = 0;
  localparam int F_ADDI = 1;
  localparam int F_LW   = 2;
  localparam int F_SW   = 3;
  localparam int F_BEQ  = 4;
  localparam int F_J    = 0;
  localparam int F_JAL  = 1;
  localparam int F_SLL  = 0;
  localparam int F_SRL  = 1;
  localparam int F_SLLV = 2;
  localparam int F_SRLV = 3;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RET    = 2'b11;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_JAL,
    CLS_CMP
  } cls_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction/strobe bundle between the control unit (master) and the datapath
// (slave). MULTICYCLE_CTRL_PERF_EN adds the performance counter outputs.
interface multicycle_ctrl_fsm_if #(
  parameter int FUNC_W = 5
`ifdef MULTICYCLE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
);
  logic              run;
  logic [1:0]        inst_type;
  logic [FUNC_W-1:0] inst_function;
  logic              stop_bit;
  logic              zero_flag;
  logic              mem_ready;
  logic              mem_rd;
  logic              mem_wr;
  logic              ir_we;
  logic              reg_we;
  logic              wb_sel;
  logic              alu_src;
  logic [3:0]        alu_op;
  logic              pc_we;
  logic [1:0]        pc_src;
  logic              st_push;
  logic              st_pop;
  logic              fault;
  logic [2:0]        state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0]  instr_retired;
  logic [CNT_W-1:0]  stall_cycles;
`endif

  modport master (
`ifdef MULTICYCLE_CTRL_PERF_EN
    output instr_retired, stall_cycles,
`endif
    input  run, inst_type, inst_function, stop_bit, zero_flag, mem_ready,
    output mem_rd, mem_wr, ir_we, reg_we, wb_sel, alu_src, alu_op,
    output pc_we, pc_src, st_push, st_pop, fault, state
  );

  modport slave (
`ifdef MULTICYCLE_CTRL_PERF_EN
    input  instr_retired, stall_cycles,
`endif
    output run, inst_type, inst_function, stop_bit, zero_flag, mem_ready,
    input  mem_rd, mem_wr, ir_we, reg_we, wb_sel, alu_src, alu_op,
    input  pc_we, pc_src, st_push, st_pop, fault, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_decode.sv
// Combinational instruction decode: legality, execution class, ALU operation
// and ALU operand select for a type/function pair.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int FUNC_W = 5
) (
  input  logic [1:0]        typ,
  input  logic [FUNC_W-1:0] func,
  output logic              illegal,
  output cls_t              cls,
  output logic [3:0]        alu_op,
  output logic              alu_src
);
  logic [31:0] fn;

  always_comb begin
    illegal = 1'b0;
    cls     = CLS_ALU;
    alu_op  = ALU_AND;
    alu_src = 1'b0;
    fn      = 32'(func);
    case (typ)
      TYPE_R: begin
        case (fn)
          F_AND:   alu_op = ALU_AND;
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_CMP:   begin alu_op = ALU_SUB; cls = CLS_CMP; end
          default: illegal = 1'b1;
        endcase
      end
      TYPE_I: begin
        alu_src = 1'b1;
        case (fn)
          F_ANDI:  alu_op = ALU_AND;
          F_ADDI:  alu_op = ALU_ADD;
          F_LW:    begin alu_op = ALU_ADD; cls = CLS_LOAD;   end
          F_SW:    begin alu_op = ALU_ADD; cls = CLS_STORE;  end
          F_BEQ:   begin alu_op = ALU_SUB; cls = CLS_BRANCH; end
          default: illegal = 1'b1;
        endcase
      end
      TYPE_J: begin
        case (fn)
          F_J:     cls = CLS_JUMP;
          F_JAL:   cls = CLS_JAL;
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        // shift-by-immediate forms take the immediate operand, variable forms do not
        case (fn)
          F_SLL:   begin alu_op = ALU_SLL; alu_src = 1'b1; end
          F_SRL:   begin alu_op = ALU_SRL; alu_src = 1'b1; end
          F_SLLV:  alu_op = ALU_SLL;
          F_SRLV:  alu_op = ALU_SRL;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle processor control FSM with memory wait states and return-stack
// occupancy tracking. Define MULTICYCLE_CTRL_PERF_EN for retire/stall counters.
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int FUNC_W      = 5,
  parameter int STACK_DEPTH = 8
`ifdef MULTICYCLE_CTRL_PERF_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_fsm_if.master bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

  state_t              state, next;
  logic [1:0]          type_q;
  logic [FUNC_W-1:0]   func_q;
  logic                stop_q;
  logic [DEPTH_W-1:0]  depth;

  logic [1:0]          typ;
  logic [FUNC_W-1:0]   func;
  logic                stop;
  logic                illegal;
  cls_t                cls;
  logic [3:0]          dec_op;
  logic                dec_src;

  logic mem_rd, mem_wr, ir_we, reg_we, wb_sel, alu_src, pc_we, st_push, st_pop, fault;
  logic [3:0] alu_op;
  logic [1:0] pc_src, base_src;
  logic       complete;

  // The IR is written on leaving IF, so ID decodes the live fields and latches them.
  assign typ  = (state == ST_ID) ? bus.inst_type     : type_q;
  assign func = (state == ST_ID) ? bus.inst_function : func_q;
  assign stop = (state == ST_ID) ? bus.stop_bit      : stop_q;

  multicycle_ctrl_decode #(.FUNC_W(FUNC_W)) u_decode (
    .typ     (typ),
    .func    (func),
    .illegal (illegal),
    .cls     (cls),
    .alu_op  (dec_op),
    .alu_src (dec_src)
  );

  always_comb begin
    next = state;
    {mem_rd, mem_wr, ir_we, reg_we, wb_sel, alu_src, pc_we, st_push, st_pop, fault} = '0;
    alu_op   = ALU_AND;
    pc_src   = PC_SEQ;
    base_src = PC_SEQ;
    complete = 1'b0;
    case (state)
      ST_IDLE: if (bus.run) next = ST_IF;
      ST_IF: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_we = 1'b1;
          next  = ST_ID;
        end
      end
      ST_ID: begin
        if (illegal || (cls == CLS_JAL && (stop || depth == FULL))) begin
          next = ST_TRAP;
        end else if (cls == CLS_JUMP || cls == CLS_JAL) begin
          complete = 1'b1;
          base_src = PC_JUMP;
        end else begin
          next = ST_EX;
        end
      end
      ST_EX: begin
        alu_op  = dec_op;
        alu_src = dec_src;
        case (cls)
          CLS_LOAD, CLS_STORE: next = ST_MEM;
          CLS_BRANCH: begin
            complete = 1'b1;
            base_src = bus.zero_flag ? PC_BRANCH : PC_SEQ;
          end
          CLS_CMP: complete = 1'b1;
          default: next = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_rd = (cls == CLS_LOAD);
        mem_wr = (cls == CLS_STORE);
        if (bus.mem_ready) begin
          if (cls == CLS_LOAD) next = ST_WB;
          else complete = 1'b1;
        end
      end
      ST_WB: begin
        reg_we   = 1'b1;
        wb_sel   = (cls == CLS_LOAD);
        complete = 1'b1;
      end
      ST_TRAP: fault = 1'b1;
      default: next = ST_IDLE;
    endcase
    // A stop-bit return takes priority over any branch/jump/sequential target.
    if (complete) begin
      if (stop && depth == '0) begin
        next = ST_TRAP;
      end else begin
        pc_we   = 1'b1;
        pc_src  = stop ? PC_RET : base_src;
        st_pop  = stop;
        st_push = (cls == CLS_JAL);
        next    = bus.run ? ST_IF : ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      type_q <= '0;
      func_q <= '0;
      stop_q <= 1'b0;
      depth  <= '0;
    end else begin
      state <= next;
      if (state == ST_ID) begin
        type_q <= bus.inst_type;
        func_q <= bus.inst_function;
        stop_q <= bus.stop_bit;
      end
      if (st_push)     depth <= depth + 1'b1;
      else if (st_pop) depth <= depth - 1'b1;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] retired, stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
      stalls  <= '0;
    end else begin
      if (pc_we) retired <= retired + 1'b1;
      if ((state == ST_IF || state == ST_MEM) && !bus.mem_ready) stalls <= stalls + 1'b1;
    end
  end

  assign bus.instr_retired = retired;
  assign bus.stall_cycles  = stalls;
`endif

  assign bus.mem_rd  = mem_rd;
  assign bus.mem_wr  = mem_wr;
  assign bus.ir_we   = ir_we;
  assign bus.reg_we  = reg_we;
  assign bus.wb_sel  = wb_sel;
  assign bus.alu_src = alu_src;
  assign bus.alu_op  = alu_op;
  assign bus.pc_we   = pc_we;
  assign bus.pc_src  = pc_src;
  assign bus.st_push = st_push;
  assign bus.st_pop  = st_pop;
  assign bus.fault   = fault;
  assign bus.state   = state;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed and random instructions checked
// cycle by cycle against a phase-list model of the instruction rules.
module tb_multicycle_ctrl_fsm;
  localparam int FW = 5;
  localparam int SD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.FUNC_W(FW)) bus ();

  multicycle_ctrl_fsm #(.FUNC_W(FW), .STACK_DEPTH(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_depth = 0;
  bit m_trap = 0;
  bit m_idle = 1;
  int m_retired = 0;
  int m_stall = 0;

  function automatic logic [15:0] obs();
    return {bus.mem_rd, bus.mem_wr, bus.ir_we, bus.reg_we, bus.wb_sel, bus.alu_src,
            bus.alu_op, bus.pc_we, bus.pc_src, bus.st_push, bus.st_pop, bus.fault};
  endfunction

  function automatic logic [15:0] mk(input bit rd, input bit wr, input bit irw, input bit rw,
                                     input bit wbs, input bit asrc, input int op, input bit pcw,
                                     input int pcs, input bit push, input bit pop, input bit flt);
    logic [3:0] o4;
    logic [1:0] p2;
    o4 = op[3:0];
    p2 = pcs[1:0];
    return {rd, wr, irw, rw, wbs, asrc, o4, pcw, p2, push, pop, flt};
  endfunction

  function automatic int maxf(input int t);
    case (t)
      0: return 3;
      1: return 4;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input int exp_st, input logic [15:0] exp_o);
    logic [2:0] es;
    es = exp_st[2:0];
    n_cmp += 2;
    assert (bus.state === es) else begin
      n_bad++;
      $error("FAIL %s state got %0d want %0d", tag, bus.state, es);
    end
    assert (obs() === exp_o) else begin
      n_bad++;
      $error("FAIL %s outputs got %h want %h", tag, obs(), exp_o);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check("reset", 0, 16'h0000);
    m_depth = 0; m_trap = 0; m_idle = 1; m_retired = 0; m_stall = 0;
    step();
    rst_n = 1'b1;
  endtask

  // One instruction: expected phases follow the latency rules, waits add repeated phases.
  task automatic do_instr(input int t, input int f, input bit s, input int wif, input int wm,
                          input bit z, input bit r);
    int ph[$];
    int rdy[$];
    bit legal, is_j, is_jal, is_lw, is_sw, is_beq, is_cmp, early_trap, trap;
    int op, base;
    bit src, rd, wr, irw, rw, wbs, pcw, push, pop;
    int pcs;
    if (m_trap) return;
    legal  = (f <= maxf(t));
    is_j   = legal && t == 2;
    is_jal = is_j && f == 1;
    is_lw  = legal && t == 1 && f == 2;
    is_sw  = legal && t == 1 && f == 3;
    is_beq = legal && t == 1 && f == 4;
    is_cmp = legal && t == 0 && f == 3;
    early_trap = !legal || (is_jal && (s || m_depth == SD));
    if (t == 0)      op = (f == 3) ? 2 : f;
    else if (t == 1) op = (f <= 1) ? f : (f <= 3) ? 1 : 2;
    else if (t == 3) op = 4 + (f % 2);
    else             op = 0;
    src  = (t == 1) || (t == 3 && f < 2);
    base = is_j ? 2 : (is_beq && z) ? 1 : 0;

    bus.inst_type = 2'(t);
    bus.inst_function = f[FW-1:0];
    bus.stop_bit = s;
    bus.zero_flag = z;
    if (m_idle) begin
      bus.run = 1'b1;
      #1 check("idle", 0, 16'h0000);
      step();
    end
    bus.run = r;

    for (int i = 0; i < wif; i++) begin ph.push_back(1); rdy.push_back(0); end
    ph.push_back(1); rdy.push_back(1);
    ph.push_back(2); rdy.push_back(1);
    if (!early_trap && !is_j) begin
      ph.push_back(3); rdy.push_back(1);
      if (is_lw || is_sw) begin
        for (int i = 0; i < wm; i++) begin ph.push_back(4); rdy.push_back(0); end
        ph.push_back(4); rdy.push_back(1);
      end
      if (!is_sw && !is_beq && !is_cmp) begin ph.push_back(5); rdy.push_back(1); end
    end

    trap = early_trap;
    for (int i = 0; i < ph.size(); i++) begin
      {rd, wr, irw, rw, wbs, pcw, push, pop} = '0;
      pcs = 0;
      bus.mem_ready = rdy[i][0];
      if (ph[i] == 1) begin rd = 1; irw = rdy[i][0]; end
      if (ph[i] == 4) begin rd = is_lw; wr = is_sw; end
      if (ph[i] == 5) begin rw = 1; wbs = is_lw; end
      if (rdy[i] == 0) m_stall++;
      if (i == ph.size() - 1 && !early_trap) begin
        if (s && m_depth == 0) trap = 1;
        else begin
          pcw = 1; pcs = s ? 3 : base; pop = s; push = is_jal;
          m_depth = m_depth + int'(push) - int'(pop);
          m_retired++;
        end
      end
      #1 check($sformatf("t%0d f%0d s%0d cyc%0d", t, f, s, i), ph[i],
               mk(rd, wr, irw, rw, wbs, (ph[i] == 3) && src, (ph[i] == 3) ? op : 0,
                  pcw, pcs, push, pop, 1'b0));
      step();
    end

    if (trap) begin
      m_trap = 1;
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
        #1 check("trap", 6, 16'h0001);
        step();
      end
    end else begin
      m_idle = !r;
    end
  endtask

  initial begin
    int t, f, wif, wm;
    bit s, z, r;
    bus.run = 1'b0; bus.inst_type = '0; bus.inst_function = '0;
    bus.stop_bit = 1'b0; bus.zero_flag = 1'b0; bus.mem_ready = 1'b0;
    do_reset();

    do_instr(0, 1, 0, 0, 0, 0, 1);                 // ADD
    // abort an ADD in EX with reset
    bus.inst_type = 2'b00; bus.inst_function = 5'd1; bus.stop_bit = 1'b0;
    bus.mem_ready = 1'b1; bus.run = 1'b1;
    #1 check("abort_if", 1, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    #1 check("abort_id", 2, 16'h0000);
    step();
    #1 check("abort_ex", 3, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    #1 check("abort_rst", 0, 16'h0000);
    step();
    rst_n = 1'b1;
    #1 check("abort_rel", 0, 16'h0000);
    step();
    m_depth = 0; m_trap = 0; m_idle = 0; m_retired = 0; m_stall = 0;

    do_instr(1, 2, 0, 0, 2, 0, 1);                 // LW, two MEM waits
    do_instr(1, 4, 0, 0, 0, 1, 1);                 // BEQ taken
    do_instr(1, 4, 0, 1, 0, 0, 1);                 // BEQ not taken, IF wait
    do_instr(1, 3, 0, 1, 1, 0, 1);                 // SW with waits
    do_instr(0, 3, 0, 0, 0, 1, 1);                 // CMP
    do_instr(3, 0, 0, 0, 0, 0, 1);                 // SLL
    do_instr(3, 3, 0, 0, 0, 0, 1);                 // SRLV
    do_instr(1, 0, 0, 0, 0, 0, 1);                 // ANDI
    do_instr(2, 0, 0, 0, 0, 0, 0);                 // J, then idle
    do_instr(2, 1, 0, 0, 0, 0, 1);                 // JAL
    do_instr(0, 1, 1, 0, 0, 0, 1);                 // ADD with return

    repeat (40) begin
      t = int'($urandom_range(0, 3));
      f = int'($urandom_range(0, maxf(t)));
      if (t == 2 && f == 1 && m_depth == SD) f = 0;
      s = ($urandom_range(0, 3) == 0) && m_depth > 0 && !(t == 2 && f == 1);
      wif = int'($urandom_range(0, 2));
      wm  = int'($urandom_range(0, 2));
      z = bit'($urandom_range(0, 1));
      r = ($urandom_range(0, 4) != 0);
      do_instr(t, f, s, wif, wm, z, r);
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    n_cmp += 2;
    assert (bus.instr_retired === 32'(m_retired)) else begin
      n_bad++;
      $error("FAIL retired got %0d want %0d", bus.instr_retired, m_retired);
    end
    assert (bus.stall_cycles === 32'(m_stall)) else begin
      n_bad++;
      $error("FAIL stalls got %0d want %0d", bus.stall_cycles, m_stall);
    end
`endif

    do_reset();
    do_instr(2, 1, 0, 0, 0, 0, 1);                 // JAL
    do_instr(2, 1, 0, 1, 0, 0, 1);                 // JAL, stack now full
    do_instr(2, 1, 0, 0, 0, 0, 1);                 // JAL overflow -> trap
    do_reset();
    do_instr(0, 1, 1, 0, 0, 0, 1);                 // return on empty stack -> trap
    do_reset();
    do_instr(0, 7, 0, 0, 0, 0, 1);                 // illegal R code -> trap
    do_reset();
    do_instr(2, 1, 1, 0, 0, 0, 1);                 // JAL with stop bit -> trap
    do_reset();
    do_instr(1, 5, 0, 0, 0, 0, 1);                 // illegal I code -> trap

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
